// File: rtl/muldiv_ex.sv
// Iterative 32x32 multiply / divide unit for the EX stage: 32 radix-2 steps
// followed by one sign-fix cycle, with pipeline stall generation for HI/LO hazards.
//
//   state | meaning
//   IDLE  | waiting for Start; MtHi/MtLo may write HI/LO
//   RUN   | one shift-add or restoring-divide step per cycle
//   FIX   | sign correction and HI/LO write-back, Done on next cycle
module muldiv_ex (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] RsData_ex,
    input  logic [31:0] RtData_ex,
    input  logic        MtHi,
    input  logic        MtLo,
    input  logic        MfHi,
    input  logic        MfLo,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done,
    output logic        Stall_md
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [5:0]  count;
    logic        is_div;
    logic        sign_a;
    logic        sign_b;
    logic        div_zero;
    logic [31:0] opnd;
    logic [63:0] acc;

    logic        in_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign in_signed = ~Op[0];
    assign abs_a     = (in_signed && RsData_ex[31]) ? (32'd0 - RsData_ex) : RsData_ex;
    assign abs_b     = (in_signed && RtData_ex[31]) ? (32'd0 - RtData_ex) : RtData_ex;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    assign div_trial = {acc[63:32], acc[31]} - {1'b0, opnd};
    assign div_next  = div_trial[32] ? {acc[62:0], 1'b0}
                                     : {div_trial[31:0], acc[30:0], 1'b1};

    assign prod_fix = (sign_a ^ sign_b) ? (64'd0 - acc) : acc;
    assign quot_fix = (sign_a ^ sign_b) ? (32'd0 - acc[31:0]) : acc[31:0];
    assign rem_fix  = sign_a ? (32'd0 - acc[63:32]) : acc[63:32];

    assign Busy     = (state != IDLE);
    assign Stall_md = Busy & (Start | MfHi | MfLo | MtHi | MtLo);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (Start) state_next = RUN;
            RUN:     if (count == 6'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            HI       <= 32'd0;
            LO       <= 32'd0;
            Done     <= 1'b0;
            count    <= 6'd0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= 32'd0;
            acc      <= 64'd0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        is_div   <= Op[1];
                        sign_a   <= in_signed & RsData_ex[31];
                        sign_b   <= in_signed & RtData_ex[31];
                        div_zero <= (RtData_ex == 32'd0);
                        count    <= 6'd0;
                        if (Op[1]) begin
                            opnd <= abs_b;
                            acc  <= {32'd0, abs_a};
                        end else begin
                            opnd <= abs_a;
                            acc  <= {32'd0, abs_b};
                        end
                    end else begin
                        if (MtHi) HI <= RsData_ex;
                        if (MtLo) LO <= RsData_ex;
                    end
                end
                RUN: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + 6'd1;
                end
                FIX: begin
                    Done <= 1'b1;
                    if (is_div) begin
                        // With a zero divisor the remainder path already reproduces the dividend.
                        HI <= rem_fix;
                        LO <= div_zero ? 32'hFFFF_FFFF : quot_fix;
                    end else begin
                        HI <= prod_fix[63:32];
                        LO <= prod_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ex.sv
// Self-checking bench for muldiv_ex: directed vector table, hand-written hazard/reset
// sequences, and random operations checked against an arithmetic reference model.
module tb_muldiv_ex;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] RsData_ex;
    logic [31:0] RtData_ex;
    logic        MtHi;
    logic        MtLo;
    logic        MfHi;
    logic        MfLo;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Done;
    logic        Stall_md;

    int checks   = 0;
    int failures = 0;

    muldiv_ex dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Op        (Op),
        .RsData_ex (RsData_ex),
        .RtData_ex (RtData_ex),
        .MtHi      (MtHi),
        .MtLo      (MtLo),
        .MfHi      (MfHi),
        .MfLo      (MfLo),
        .HI        (HI),
        .LO        (LO),
        .Busy      (Busy),
        .Done      (Done),
        .Stall_md  (Stall_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Result as {HI, LO}.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin
                p = sa * sb;
                return p;
            end
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Start     = 1'b1;
        Op        = op;
        RsData_ex = a;
        RtData_ex = b;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n, output bit held);
        logic [31:0] hi0, lo0;
        hi0    = HI;
        lo0    = LO;
        lat    = 0;
        busy_n = 0;
        held   = 1'b1;
        while (!Done && lat < 100) begin
            if (Busy) busy_n++;
            if (HI !== hi0 || LO !== lo0) held = 1'b0;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
        int lat, busy_n;
        bit held;
        issue(op, a, b);
        wait_done(lat, busy_n, held);
        check($sformatf("%s_latency", name), 64'(lat), 64'd33);
        check($sformatf("%s_busy_cycles", name), 64'(busy_n), 64'd33);
        check($sformatf("%s_hilo_held", name), 64'(held), 64'd1);
        check($sformatf("%s_busy_in_done", name), 64'(Busy), 64'd0);
        check($sformatf("%s_result", name), {HI, LO}, exp);
    endtask

    initial begin
        int lat, busy_n, n;
        bit held, ok, saw;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{2'd0, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
        vecs[3]  = '{2'd3, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF};
        vecs[4]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[5]  = '{2'd2, 32'hFFFF_FFFB, 32'd0,         64'hFFFF_FFFB_FFFF_FFFF};
        vecs[6]  = '{2'd2, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
        vecs[7]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[8]  = '{2'd3, 32'hFFFF_FFFF, 32'd10,        64'h0000_0005_1999_9999};
        vecs[9]  = '{2'd0, 32'h0001_0000, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_0000};
        vecs[10] = '{2'd1, 32'd0,         32'h0001_2345, 64'h0};

        reset = 1'b1; Start = 1'b0; Op = 2'd0; RsData_ex = 32'd0; RtData_ex = 32'd0;
        MtHi = 1'b0; MtLo = 1'b0; MfHi = 1'b1; MfLo = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hilo", {HI, LO}, 64'd0);
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_done", 64'(Done), 64'd0);
        check("reset_stall", 64'(Stall_md), 64'd0);
        reset = 1'b0;
        MfHi  = 1'b0;
        @(negedge clk);
        check("post_reset_busy", 64'(Busy), 64'd0);

        // Moves in IDLE
        MtHi = 1'b1; RsData_ex = 32'h1234_5678;
        @(negedge clk);
        MtHi = 1'b0;
        check("mthi_idle", {HI, LO}, {32'h1234_5678, 32'd0});
        MtLo = 1'b1; RsData_ex = 32'hCAFE_F00D;
        @(negedge clk);
        MtLo = 1'b0;
        check("mtlo_idle", {HI, LO}, {32'h1234_5678, 32'hCAFE_F00D});

        // Start and MtHi together: the move is dropped
        Start = 1'b1; MtHi = 1'b1; Op = 2'd0; RsData_ex = 32'd5; RtData_ex = 32'd6;
        @(posedge clk);
        @(negedge clk);
        Start = 1'b0; MtHi = 1'b0;
        check("start_prio_hi", 64'(HI), 64'h1234_5678);
        check("start_prio_busy", 64'(Busy), 64'd1);
        wait_done(lat, busy_n, held);
        check("start_prio_result", {HI, LO}, 64'd30);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
            @(negedge clk);
            check($sformatf("vec%0d_done_once", i), 64'(Done), 64'd0);
        end

        // Back-to-back start in the Done cycle
        @(negedge clk);
        do_op("b2b_first", 2'd0, 32'd6, 32'd7, 64'd42);
        do_op("b2b_second", 2'd3, 32'd42, 32'd5, {32'd2, 32'd8});

        // MtHi while busy: stalled, ignored, then taken after Done
        @(negedge clk);
        issue(2'd1, 32'd3, 32'd4);
        repeat (3) @(negedge clk);
        MtHi = 1'b1; RsData_ex = 32'hA5A5_A5A5;
        #1;
        check("mthi_busy_stall", 64'(Stall_md), 64'd1);
        wait_done(lat, busy_n, held);
        check("mthi_busy_held", 64'(held), 64'd1);
        check("mthi_busy_result", {HI, LO}, {32'd0, 32'd12});
        check("mthi_busy_stall_done", 64'(Stall_md), 64'd0);
        @(negedge clk);
        MtHi = 1'b0;
        check("mthi_after_done", {HI, LO}, {32'hA5A5_A5A5, 32'd12});

        // MfLo during an operation stalls until the Done cycle
        @(negedge clk);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);
        repeat (4) @(negedge clk);
        MfLo = 1'b1;
        #1;
        n  = 0;
        ok = 1'b1;
        while (!Done && n < 100) begin
            if (!Stall_md) ok = 1'b0;
            n++;
            @(negedge clk);
        end
        check("mflo_stall_held", 64'(ok), 64'd1);
        check("mflo_done_seen", 64'(Done), 64'd1);
        check("mflo_stall_released", 64'(Stall_md), 64'd0);
        check("mflo_lo", 64'(LO), 64'hFFFF_FFFD);
        MfLo = 1'b0;

        // Reset in the middle of an operation
        @(negedge clk);
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", 64'(Busy), 64'd0);
        check("midreset_hilo", {HI, LO}, 64'd0);
        check("midreset_done", 64'(Done), 64'd0);
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (Done) saw = 1'b1;
        end
        check("midreset_no_done", 64'(saw), 64'd0);
        @(negedge clk);
        do_op("after_reset", 2'd3, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF});

        // Random operations against the reference model
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = $urandom_range(0, 1000);
                default: ;
            endcase
            @(negedge clk);
            do_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, ref_model(rop, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
